// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the parametrised UART receiver.
// Vote-tick offsets place the three majority samples around the bit centre.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Samples are taken at OSR/2-VOTE_PRE, OSR/2 and OSR/2+VOTE_POST; the vote resolves on the last one.
   localparam int VOTE_PRE  = 1;
   localparam int VOTE_POST = 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK_WAIT
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the asynchronous serial line plus the sample history
// that feeds the 3-way majority vote.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic i_divided_clk,
   input  logic i_rst,
   input  logic en,
   input  logic rx,
   output logic rx_sync,
   output logic vote
);

   logic [1:0] sync_ff;
   logic [VOTE_PRE+VOTE_POST-1:0] hist;

   // NOTE: flops use non-blocking assignments and an async reset; the line idles high, so reset to 1.
   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_ff <= '1;
         hist    <= '1;
      end else begin
         sync_ff <= {sync_ff[0], rx};
         if (en) hist <= {hist[0], sync_ff[1]};
      end
   end

   assign rx_sync = sync_ff[1];

   // The two previous enabled ticks plus the current one form the three samples.
   assign vote = maj3(hist[1], hist[0], rx_sync);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote bit decisions, start-glitch rejection,
// parity/framing/overrun flags, break handling and a valid/ready output stage.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA   = 8,
   parameter int PARITY = 0,
   parameter int STOP   = 1,
   parameter int OSR    = 16
) (
   input  logic            i_divided_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_rx,
   input  logic            i_ready,
   output logic [DATA-1:0] o_data,
   output logic            o_valid,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_overrun,
   output logic            o_busy
);

   localparam int TICK_W = $clog2(OSR);
   localparam int IDX_W  = $clog2(DATA + 1);

   localparam logic [TICK_W-1:0] VOTE_TICK = TICK_W'(OSR / 2 + VOTE_POST);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OSR - 1);
   localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA - 1);
   localparam logic              LAST_STOP = 1'(STOP - 1);
   localparam logic              ODD_FLIP  = (PARITY == PARITY_ODD);

   logic rx_sync;
   logic vote;

   uart_rx_sampler u_sampler (
      .i_divided_clk (i_divided_clk),
      .i_rst         (i_rst),
      .en            (i_en),
      .rx            (i_rx),
      .rx_sync       (rx_sync),
      .vote          (vote)
   );

   rx_state_e         state, state_d;
   logic [TICK_W-1:0] tick, tick_d;
   logic [IDX_W-1:0]  idx, idx_d;
   logic              stop_cnt, stop_d;
   logic [DATA-1:0]   shreg, shreg_d;
   logic              perr, perr_d;
   logic              ferr, ferr_d;
   logic              complete;

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= RX_IDLE;
         tick     <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         state    <= state_d;
         tick     <= tick_d;
         idx      <= idx_d;
         stop_cnt <= stop_d;
         shreg    <= shreg_d;
         perr     <= perr_d;
         ferr     <= ferr_d;
      end
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state;
      tick_d   = tick;
      idx_d    = idx;
      stop_d   = stop_cnt;
      shreg_d  = shreg;
      perr_d   = perr;
      ferr_d   = ferr;
      complete = 1'b0;

      if (i_en) begin
         if (state != RX_IDLE && state != RX_BREAK_WAIT)
            tick_d = (tick == LAST_TICK) ? '0 : tick + TICK_W'(1);

         case (state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  state_d = RX_START;
                  tick_d  = '0;
                  idx_d   = '0;
                  stop_d  = 1'b0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end
            end
            RX_START: begin
               if (tick == VOTE_TICK && vote) state_d = RX_IDLE;
               else if (tick == LAST_TICK) state_d = RX_DATA;
            end
            RX_DATA: begin
               // LSB arrives first and ends up at bit 0 after DATA shifts.
               if (tick == VOTE_TICK) shreg_d = {vote, shreg[DATA-1:1]};
               if (tick == LAST_TICK) begin
                  if (idx == LAST_BIT) begin
                     state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                     stop_d  = 1'b0;
                  end else begin
                     idx_d = idx + IDX_W'(1);
                  end
               end
            end
            RX_PARITY: begin
               if (tick == VOTE_TICK && vote != ((^shreg) ^ ODD_FLIP)) perr_d = 1'b1;
               if (tick == LAST_TICK) state_d = RX_STOP;
            end
            RX_STOP: begin
               if (tick == VOTE_TICK) begin
                  if (!vote) ferr_d = 1'b1;
                  if (stop_cnt == LAST_STOP) begin
                     complete = 1'b1;
                     state_d  = rx_sync ? RX_IDLE : RX_BREAK_WAIT;
                  end
               end else if (tick == LAST_TICK) begin
                  stop_d = 1'b1;
               end
            end
            RX_BREAK_WAIT: begin
               if (rx_sync) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   // Output stage runs every clock regardless of i_en.
   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (complete) begin
            if (!o_valid || i_ready) begin
               o_data       <= shreg;
               o_valid      <= 1'b1;
               o_parity_err <= perr;
               o_frame_err  <= ferr_d;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized bench for uart_rx_param (DATA=8, even parity, 1 stop, OSR=16).
// Delivered words are collected by a monitor and compared with words predicted from the sent frames.
module tb_uart_rx_param;

   localparam int DATA   = 8;
   localparam int PARITY = 2;
   localparam int STOP   = 1;
   localparam int OSR    = 16;

   typedef struct packed {
      logic [DATA-1:0] d;
      logic            pe;
      logic            fe;
   } word_t;

   logic            clk = 1'b0;
   logic            i_rst;
   logic            i_en;
   logic            i_rx;
   logic            i_ready;
   logic [DATA-1:0] o_data;
   logic            o_valid;
   logic            o_parity_err;
   logic            o_frame_err;
   logic            o_overrun;
   logic            o_busy;

   int checks = 0;
   int errors = 0;
   bit en_rand = 1'b0;

   word_t exp_q[$];
   word_t got[0:255];
   int    got_n = 0;
   int    rd = 0;
   int    ovr_cnt = 0;
   int    valid_cycles = 0;
   int    busy_cycles = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.DATA(DATA), .PARITY(PARITY), .STOP(STOP), .OSR(OSR)) dut (
      .i_divided_clk (clk),
      .i_rst         (i_rst),
      .i_en          (i_en),
      .i_rx          (i_rx),
      .i_ready       (i_ready),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_parity_err  (o_parity_err),
      .o_frame_err   (o_frame_err),
      .o_overrun     (o_overrun),
      .o_busy        (o_busy)
   );

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!i_rst) begin
         if (o_valid && i_ready && got_n < 256) begin
            got[got_n] <= '{d: o_data, pe: o_parity_err, fe: o_frame_err};
            got_n <= got_n + 1;
         end
         if (o_overrun) ovr_cnt <= ovr_cnt + 1;
         if (o_valid) valid_cycles <= valid_cycles + 1;
         if (o_busy) busy_cycles <= busy_cycles + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds the line at b for OSR enabled ticks; i_en is randomized when en_rand is set.
   task automatic drive_bit(input logic b);
      int n;
      n = 0;
      i_rx = b;
      while (n < OSR) begin
         i_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         #1;
         if (i_en) n++;
      end
      i_en = 1'b1;
   endtask

   // Sends one frame followed by two idle bit times; optionally records the expected delivery.
   task automatic send_frame(input logic [DATA-1:0] d, input bit bad_par, input logic stop_bit,
                             input bit expect_it);
      logic pbit;
      word_t w;
      pbit = 1'($countones(d) % 2);
      if (bad_par) pbit = ~pbit;
      drive_bit(1'b0);
      for (int i = 0; i < DATA; i++) drive_bit(d[i]);
      drive_bit(pbit);
      drive_bit(stop_bit);
      drive_bit(1'b1);
      drive_bit(1'b1);
      if (expect_it) begin
         // Even parity: data ones plus parity bit must total an even number.
         w.d  = d;
         w.pe = (($countones(d) + int'(pbit)) % 2) != 0;
         w.fe = (stop_bit == 1'b0);
         exp_q.push_back(w);
      end
   endtask

   task automatic compare_words(input string tag);
      word_t e;
      check({tag, "_count"}, 32'(got_n - rd), 32'(exp_q.size()));
      while (exp_q.size() > 0 && rd < got_n) begin
         e = exp_q.pop_front();
         check(tag, 32'(got[rd]), 32'(e));
         rd++;
      end
      exp_q.delete();
      rd = got_n;
   endtask

   task automatic reset_pulse();
      i_rst = 1'b1;
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_flags", 32'({o_parity_err, o_frame_err, o_overrun}), 0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      int v0;
      int b0;
      int o0;
      int g0;
      logic [DATA-1:0] rd_data;

      i_rst = 1'b1;
      i_en = 1'b1;
      i_rx = 1'b1;
      i_ready = 1'b1;
      cycles(3);
      @(negedge clk);
      check("reset_outputs", 32'({o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy}), 0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      drive_bit(1'b1);
      drive_bit(1'b1);

      // Clean frame, consumer always ready.
      v0 = valid_cycles;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      check("a5_valid_cycles", 32'(valid_cycles - v0), 1);
      compare_words("a5");

      // Start glitch: four low ticks, then idle.
      b0 = busy_cycles;
      g0 = got_n;
      i_rx = 1'b0;
      cycles(4);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check("glitch_busy_seen", 32'(busy_cycles > b0), 1);
      check("glitch_no_word", 32'(got_n - g0), 0);
      check("glitch_idle", 32'(o_busy), 0);

      // Wrong parity bit.
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      compare_words("par_err");

      // Break: line low for 20 bit times.
      g0 = got_n;
      for (int i = 0; i < 20; i++) drive_bit(1'b0);
      check("break_one_word", 32'(got_n - g0), 1);
      check("break_waiting", 32'(o_busy), 1);
      exp_q.push_back('{d: '0, pe: 1'b0, fe: 1'b1});
      drive_bit(1'b1);
      drive_bit(1'b1);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1);
      compare_words("break");

      // Overrun: consumer stalled across two frames.
      i_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rd_data = o_data;
      check("ovr_data_kept", 32'(rd_data), 32'h11);
      check("ovr_valid_held", 32'(o_valid), 1);
      check("ovr_pulses", 32'(ovr_cnt - o0), 1);
      @(posedge clk);
      #1;
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ovr_valid_drop", 32'(o_valid), 0);
      compare_words("overrun");

      // Randomized frames with occasional parity and stop-bit faults.
      for (int k = 0; k < 6; k++) begin
         send_frame(DATA'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'b1);
      end
      compare_words("random");

      // Reset mid-frame (data bit 4 of 0x77), then a clean frame; repeated with i_en toggling.
      for (int pass = 0; pass < 2; pass++) begin
         en_rand = (pass == 1);
         drive_bit(1'b0);
         for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
         i_rx = 1'b1;
         cycles(OSR / 2);
         reset_pulse();
         drive_bit(1'b1);
         drive_bit(1'b1);
         send_frame(8'h81, 1'b0, 1'b1, 1'b1);
         compare_words(pass == 0 ? "rst_mid" : "rst_mid_en");
      end
      en_rand = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
